// File: rtl/escalator_pkg.sv
// Shared definitions for the escalator motor controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package escalator_pkg;

  // FSM states; the encoding is visible on uo_out[6:5]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_STANDBY = 2'b10,
    ST_ESTOP   = 2'b11
  } state_e;

  // Default inactivity timeouts, in core clock cycles
  localparam int unsigned RUN_TIMEOUT_DEF  = 100;
  localparam int unsigned SLOW_TIMEOUT_DEF = 200;
  localparam int unsigned TIMER_W_DEF      = 16;

  // Bit positions within ui_in (and within the synchronised copy)
  localparam int SNS_BOTTOM = 0;
  localparam int SNS_TOP    = 1;
  localparam int SNS_DIR    = 2;
  localparam int SNS_ESTOP  = 3;
  localparam int SNS_RESUME = 4;
  localparam int SYNC_W     = 5;

  // Passenger counter ceiling
  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/escalator_timer.sv
// Inactivity countdown: load N, decrement to zero, pulse done on the 1->0 step.
// Latency: done is registered, asserted N cycles after the load edge.
// Backpressure: none; clear beats load, load beats decrement.
module escalator_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               clear,
  output logic               done,
  output logic               active
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               done_q, done_d;

  // Next count and the done strobe for the final decrement step
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
      done_d  = (count_q == TIMER_W'(1));
    end
  end

  // Countdown and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done   = done_q;
  assign active = (count_q != '0);

endmodule

// File: rtl/escalator_controller.sv
// Escalator motor controller: sensors start/hold the motor, timeouts drop to slow then stop.
// Latency: ui_in is seen by the FSM 2 cycles after it is sampled; outputs follow one edge later.
// Backpressure: none; every input is sampled every cycle.
module escalator_controller
  import escalator_pkg::*;
#(
  parameter int unsigned RUN_TIMEOUT  = RUN_TIMEOUT_DEF,
  parameter int unsigned SLOW_TIMEOUT = SLOW_TIMEOUT_DEF,
  parameter int unsigned TIMER_W      = TIMER_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,     // active-high despite the harness name
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [TIMER_W-1:0] RUN_VAL  = TIMER_W'(RUN_TIMEOUT);
  localparam logic [TIMER_W-1:0] SLOW_VAL = TIMER_W'(SLOW_TIMEOUT);

  logic [SYNC_W-1:0] sync1_q, sync2_q, prev_q;
  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic              ww_q, ww_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cnt_inc;

  logic               tmr_load, tmr_clear, tmr_done, tmr_active;
  logic [TIMER_W-1:0] tmr_value;

  logic bottom_s, top_s, dir_s, estop_s;
  logic entry_s, exit_s, entry_rise, resume_rise;

  // ena, the bidirectional inputs and the spare ui_in bits carry no function
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

  // Two-flop synchroniser plus one history stage for rising-edge detection
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= ui_in[SYNC_W-1:0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign bottom_s = sync2_q[SNS_BOTTOM];
  assign top_s    = sync2_q[SNS_TOP];
  assign dir_s    = sync2_q[SNS_DIR];
  assign estop_s  = sync2_q[SNS_ESTOP];

  // Entry is the landing passengers board from for the latched direction
  assign entry_s     = dir_q ? top_s : bottom_s;
  assign exit_s      = dir_q ? bottom_s : top_s;
  assign entry_rise  = entry_s & ~(dir_q ? prev_q[SNS_TOP] : prev_q[SNS_BOTTOM]);
  assign resume_rise = sync2_q[SNS_RESUME] & ~prev_q[SNS_RESUME];

  escalator_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .clear  (tmr_clear),
    .done   (tmr_done),
    .active (tmr_active)
  );

  // Next state, timer commands, wrong-way flag and count request
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = RUN_VAL;
    tmr_clear = 1'b0;
    ww_d      = 1'b0;
    cnt_inc   = 1'b0;
    if (estop_s) begin
      // e-stop overrides everything, including a pending timeout
      state_d   = ST_ESTOP;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (entry_s) begin
            state_d  = ST_RUN;
            tmr_load = 1'b1;
            cnt_inc  = 1'b1;
          end else if (exit_s) begin
            ww_d = 1'b1;
          end
        end
        ST_RUN: begin
          cnt_inc = entry_rise;
          // any activity keeps full speed; a sensor beats a same-cycle timeout
          if (bottom_s || top_s) begin
            tmr_load = 1'b1;
          end else if (tmr_done) begin
            state_d   = ST_STANDBY;
            tmr_load  = 1'b1;
            tmr_value = SLOW_VAL;
          end
        end
        ST_STANDBY: begin
          cnt_inc = entry_rise;
          if (entry_s) begin
            state_d  = ST_RUN;
            tmr_load = 1'b1;
          end else if (tmr_done) begin
            state_d = ST_IDLE;
          end
        end
        ST_ESTOP: begin
          tmr_clear = 1'b1;
          if (resume_rise) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Direction is only re-latched while stopped so a running escalator never reverses
  always_comb begin
    dir_d = dir_q;
    if (state_q == ST_IDLE) begin
      dir_d = dir_s;
    end
  end

  // Saturating passenger count
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // FSM, direction, wrong-way and counter registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      ww_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ww_q    <= ww_d;
      cnt_q   <= cnt_d;
    end
  end

  assign uo_out = {tmr_active,
                   state_q,
                   ww_q,
                   (state_q == ST_ESTOP),
                   (state_q == ST_RUN),
                   dir_q,
                   (state_q == ST_RUN) || (state_q == ST_STANDBY)};

  assign uio_out = cnt_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_escalator_controller.sv
// Bench for escalator_controller: fixed vector table, corner sequences, random vs model.
module tb_escalator_controller;

  localparam int RUN_T  = 100;
  localparam int SLOW_T = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  escalator_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 standby, 3 estop; timer kept as an absolute deadline
  int         m_mode;
  int         m_cnt;
  longint     m_now;
  longint     m_deadline;
  bit         m_dir;
  bit         m_ww;
  logic [4:0] m_hist[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (4) m_hist.push_front(5'd0);
    m_mode = 0; m_cnt = 0; m_now = 0; m_deadline = -1; m_dir = 1'b0; m_ww = 1'b0;
  endtask

  task automatic bump();
    if (m_cnt < 255) m_cnt++;
  endtask

  // One clock edge of the model; v is the ui_in value sampled at that edge
  task automatic model_step(input logic [4:0] v);
    logic [4:0] s, p;
    bit entry, exitv, rise, expired;
    int nmode;
    m_now++;
    m_hist.push_front(v);
    s = m_hist[2];             // what the controller sees: sampled two edges earlier
    p = m_hist[3];
    void'(m_hist.pop_back());
    entry   = m_dir ? s[1] : s[0];
    exitv   = m_dir ? s[0] : s[1];
    rise    = entry && !(m_dir ? p[1] : p[0]);
    expired = (m_now == m_deadline);
    nmode   = m_mode;
    m_ww    = 1'b0;
    if (s[3]) begin
      nmode = 3;
      m_deadline = -1;
    end else begin
      case (m_mode)
        0: begin
          if (entry) begin nmode = 1; m_deadline = m_now + RUN_T + 1; bump(); end
          else if (exitv) m_ww = 1'b1;
        end
        1: begin
          if (rise) bump();
          if (s[0] || s[1]) m_deadline = m_now + RUN_T + 1;
          else if (expired) begin nmode = 2; m_deadline = m_now + SLOW_T + 1; end
        end
        2: begin
          if (rise) bump();
          if (entry) begin nmode = 1; m_deadline = m_now + RUN_T + 1; end
          else if (expired) nmode = 0;
        end
        default: if (s[4] && !p[4]) nmode = 0;
      endcase
    end
    if (m_mode == 0) m_dir = s[2];
    m_mode = nmode;
  endtask

  function automatic logic [7:0] m_uo();
    logic act;
    act = (m_deadline > 0) && (m_now < m_deadline - 1);
    return {act, 2'(m_mode), m_ww, (m_mode == 3), (m_mode == 1), m_dir,
            (m_mode == 1) || (m_mode == 2)};
  endfunction

  // Drive one cycle, advance the model, compare every output
  task automatic tick(input logic [7:0] v);
    ui_in = v;
    @(posedge clk);
    model_step(v[4:0]);
    #1;
    chk("uo_out vs model", uo_out, m_uo());
    chk("uio_out vs model", uio_out, 8'(m_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    ui_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] ui;
    int         cyc;
    logic [7:0] uo;
    logic [7:0] cnt;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0] v;
    int dens;
    bit rdir;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;

    // Vectors from reset: start, run timeout, standby timeout, e-stop, wrong way, down start
    tbl.push_back('{8'h00,   3, 8'h00, 8'h00, "idle quiet"});
    tbl.push_back('{8'h01,   1, 8'h00, 8'h00, "pulse in sync"});
    tbl.push_back('{8'h00,   1, 8'h00, 8'h00, "still idle"});
    tbl.push_back('{8'h00,   1, 8'hA5, 8'h01, "run start"});
    tbl.push_back('{8'h00,  98, 8'hA5, 8'h01, "run held"});
    tbl.push_back('{8'h00,   1, 8'hA5, 8'h01, "run timer last"});
    tbl.push_back('{8'h00,   1, 8'h25, 8'h01, "run timer zero"});
    tbl.push_back('{8'h00,   1, 8'hC1, 8'h01, "standby"});
    tbl.push_back('{8'h00, 199, 8'hC1, 8'h01, "standby held"});
    tbl.push_back('{8'h00,   1, 8'h41, 8'h01, "standby zero"});
    tbl.push_back('{8'h00,   1, 8'h00, 8'h01, "back idle"});
    tbl.push_back('{8'h08,   2, 8'h00, 8'h01, "estop in sync"});
    tbl.push_back('{8'h08,   1, 8'h68, 8'h01, "estop"});
    tbl.push_back('{8'h18,   4, 8'h68, 8'h01, "resume while estop"});
    tbl.push_back('{8'h08,   3, 8'h68, 8'h01, "resume drop"});
    tbl.push_back('{8'h00,   3, 8'h68, 8'h01, "estop low"});
    tbl.push_back('{8'h10,   2, 8'h68, 8'h01, "resume in sync"});
    tbl.push_back('{8'h10,   1, 8'h00, 8'h01, "resumed idle"});
    tbl.push_back('{8'h04,   3, 8'h02, 8'h01, "dir down idle"});
    tbl.push_back('{8'h05,   3, 8'h12, 8'h01, "wrong way"});
    tbl.push_back('{8'h07,   3, 8'hA7, 8'h02, "down start"});
    tbl.push_back('{8'h03,   3, 8'hA7, 8'h02, "dir toggle in run"});

    do_reset();
    foreach (tbl[i]) begin
      repeat (tbl[i].cyc) tick(tbl[i].ui);
      chk({"table ", tbl[i].name, " uo_out"}, uo_out, tbl[i].uo);
      chk({"table ", tbl[i].name, " count"}, uio_out, tbl[i].cnt);
    end

    // Quiet period: run -> standby -> idle, direction returns to up
    repeat (320) tick(8'h00);
    chk("quiet back to idle", uo_out, 8'h00);

    // Periodic sensor activity keeps RUN; only bottom (entry) pulses count
    do_reset();
    tick(8'h01); tick(8'h00); tick(8'h00);
    chk("periodic run start", {6'd0, uo_out[6:5]}, 8'h01);
    for (int k = 0; k < 500; k++) begin
      v = (k % 50 == 25) ? (((k / 50) % 2 == 1) ? 8'h02 : 8'h01) : 8'h00;
      tick(v);
      if (uo_out[6:5] != 2'b01) chk("periodic stays run", {6'd0, uo_out[6:5]}, 8'h01);
    end
    chk("periodic still run", {6'd0, uo_out[6:5]}, 8'h01);
    chk("periodic entry count", uio_out, 8'd6);

    // E-stop from RUN takes effect within 3 cycles
    repeat (3) tick(8'h08);
    chk("estop state", {6'd0, uo_out[6:5]}, 8'h03);
    chk("estop motor/led", {6'd0, uo_out[3], uo_out[0]}, 8'h02);
    repeat (3) tick(8'h00);
    repeat (3) tick(8'h10);
    chk("estop resumed", uo_out, 8'h00);

    // 300 entry edges saturate the counter
    for (int i = 0; i < 300; i++) begin
      tick(8'h01);
      tick(8'h00);
    end
    chk("count saturated", uio_out, 8'hFF);
    repeat (4) tick(8'h01);
    chk("count held at max", uio_out, 8'hFF);

    // Random traffic against the model, with an asynchronous reset midway
    do_reset();
    rdir = 1'b0;
    for (int seg = 0; seg < 12; seg++) begin
      dens = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) rdir = ~rdir;
      if (seg == 6) begin
        rst_n = 1'b1;
        #2;
        chk("async reset uo_out", uo_out, 8'h00);
        chk("async reset uio_out", uio_out, 8'h00);
        do_reset();
      end
      for (int c = 0; c < 300; c++) begin
        v = 8'h00;
        v[0] = (dens == 1) ? ($urandom_range(0, 39) == 0) : (dens == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
        v[1] = (dens == 1) ? ($urandom_range(0, 39) == 0) : (dens == 2) ? ($urandom_range(0, 4) == 0) : 1'b0;
        v[2] = ($urandom_range(0, 49) == 0) ? ~rdir : rdir;
        v[3] = ($urandom_range(0, 149) == 0);
        v[4] = ($urandom_range(0, 9) == 0);
        v[7:5] = 3'($urandom_range(0, 7));
        tick(v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
